// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and buffered load results onto the register file write port.
// Optional WB_BYPASS_EN macro adds two combinational forwarding lookups.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_rd,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [ADDR_W-1:0]          mem_rd,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       mem_ready,
  output logic [ADDR_W-1:0]          write_reg,
  output logic [DATA_W-1:0]          write_data,
  output logic                       write_enable,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W-1:0]          byp_reg1,
  input  logic [ADDR_W-1:0]          byp_reg2,
  output logic                       byp_hit1,
  output logic                       byp_hit2,
  output logic [DATA_W-1:0]          byp_data1,
  output logic [DATA_W-1:0]          byp_data2,
`endif
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ALU_PRI, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fifo_rd   [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [SC_W-1:0]   starve;

  logic fifo_empty;
  logic alu_win;
  logic deq;
  logic enq;

  assign alu_ready  = (state == ALU_PRI);
  assign mem_ready  = (count != CNT_W'(DEPTH));
  assign fifo_count = count;
  assign fifo_empty = (count == '0);

  // rd==0 transfers are consumed without claiming the port
  assign alu_win = alu_valid & alu_ready & (alu_rd != '0);
  assign deq     = ~fifo_empty & (~alu_ready | ~alu_win);
  assign enq     = mem_valid & mem_ready & (mem_rd != '0);

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ALU_PRI;
      starve       <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      write_enable <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= alu_win | deq;
      if (alu_win) begin
        write_reg  <= alu_rd;
        write_data <= alu_data;
      end else if (deq) begin
        write_reg  <= fifo_rd[rd_ptr];
        write_data <= fifo_data[rd_ptr];
      end

      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      case (state)
        ALU_PRI: begin
          if (alu_win && !fifo_empty) begin
            starve <= starve + SC_W'(1);
            if (starve == SC_W'(STARVE_LIMIT - 1)) state <= DRAIN;
          end else begin
            starve <= '0;
          end
        end
        DRAIN: begin
          // one forced dequeue (or none if empty), then back to ALU priority
          state  <= ALU_PRI;
          starve <= '0;
        end
        default: begin
          state  <= ALU_PRI;
          starve <= '0;
        end
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  // Later (younger) FIFO entries override older ones; the write stage overrides the FIFO.
  function automatic logic [DATA_W:0] byp_lookup(input logic [ADDR_W-1:0] r);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (fifo_rd[idx] == r)) res = {1'b1, fifo_data[idx]};
    end
    if (write_enable && (write_reg == r)) res = {1'b1, write_data};
    if (r == '0) res = '0;
    return res;
  endfunction

  always_comb begin
    {byp_hit1, byp_data1} = byp_lookup(byp_reg1);
    {byp_hit2, byp_data2} = byp_lookup(byp_reg2);
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a cycle-level reference model predicts each write and status.
module tb_wb_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 32;
  localparam int CNT_W        = $clog2(DEPTH) + 1;
  localparam int EW           = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              write_enable;
  logic [CNT_W-1:0]  fifo_count;
`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] byp_reg1;
  logic [ADDR_W-1:0] byp_reg2;
  logic              byp_hit1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data1;
  logic [DATA_W-1:0] byp_data2;
`endif

  wb_arbiter #(
    .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .write_reg(write_reg), .write_data(write_data), .write_enable(write_enable),
`ifdef WB_BYPASS_EN
    .byp_reg1(byp_reg1), .byp_reg2(byp_reg2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2),
`endif
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int            m_state = 0;   // 0 = ALU priority, 1 = drain
  int            m_starve = 0;
  logic [EW-1:0] mq[$];
  logic [EW-1:0] sb[$];
  bit            exp_we = 0;

  task automatic step();
    logic [EW-1:0]    e;
    logic [EW-1:0]    got;
    logic [CNT_W-1:0] ec;
    bit win, dq, en;
    int n;
    n = mq.size();
    e = '0;
    if (reset) begin
      mq.delete();
      m_state = 0;
      m_starve = 0;
      exp_we = 0;
    end else begin
      win = alu_valid && (m_state == 0) && (alu_rd != 0);
      dq  = (n > 0) && ((m_state == 1) || !win);
      en  = mem_valid && (n != DEPTH) && (mem_rd != 0);
      exp_we = win || dq;
      if (win) e = {alu_rd, alu_data};
      else if (dq) e = mq.pop_front();
      if (exp_we) sb.push_back(e);
      if (en) mq.push_back({mem_rd, mem_data});
      if (m_state == 1) begin
        m_state = 0;
        m_starve = 0;
      end else if (win && n > 0) begin
        m_starve++;
        if (m_starve == STARVE_LIMIT) m_state = 1;
      end else begin
        m_starve = 0;
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (write_enable !== exp_we) begin
      miscompares++;
      $display("FAIL write_enable: got %0b want %0b", write_enable, exp_we);
    end
    if (exp_we) begin
      got = sb.pop_front();
      vectors++;
      if ({write_reg, write_data} !== got) begin
        miscompares++;
        $display("FAIL write_port: got rd=%0d data=%h want rd=%0d data=%h",
                 write_reg, write_data, got[EW-1:DATA_W], got[DATA_W-1:0]);
      end
    end
    vectors++;
    if (alu_ready !== (m_state == 0)) begin
      miscompares++;
      $display("FAIL alu_ready: got %0b want %0b", alu_ready, (m_state == 0));
    end
    vectors++;
    if (mem_ready !== (mq.size() != DEPTH)) begin
      miscompares++;
      $display("FAIL mem_ready: got %0b want %0b", mem_ready, (mq.size() != DEPTH));
    end
    ec = CNT_W'(mq.size());
    vectors++;
    if (fifo_count !== ec) begin
      miscompares++;
      $display("FAIL fifo_count: got %0d want %0d", fifo_count, ec);
    end
  endtask

  task automatic idle(input int n);
    alu_valid = 0;
    mem_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1;
    mem_valid = 1;
    mem_rd = 5;
    mem_data = 32'h5555_5555;
    alu_valid = 0;
    step();
    step();
    vectors++;
    if (write_enable !== 1'b0 || fifo_count !== '0 || mem_ready !== 1'b1 || alu_ready !== 1'b1 ||
        write_reg !== '0 || write_data !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got we=%0b cnt=%0d mr=%0b ar=%0b rd=%0d data=%h want 0 0 1 1 0 0",
               write_enable, fifo_count, mem_ready, alu_ready, write_reg, write_data);
    end
    reset = 0;
    mem_valid = 0;
  endtask

  task automatic test_alu_single();
    alu_valid = 1;
    alu_rd = 3;
    alu_data = 32'hDEAD_BEEF;
    step();
    vectors++;
    if (write_enable !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL alu_single: got we=%0b rd=%0d data=%h want 1 3 deadbeef",
               write_enable, write_reg, write_data);
    end
    alu_valid = 0;
    step();
    vectors++;
    if (write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_pulse: got we=%0b want 0", write_enable);
    end
  endtask

  task automatic test_zero_rd();
    int pulses;
    pulses = 0;
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1111_1111;
    mem_valid = 1; mem_rd = 0; mem_data = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      step();
      if (write_enable) pulses++;
    end
    vectors++;
    if (pulses != 0 || fifo_count !== '0) begin
      miscompares++;
      $display("FAIL zero_rd: got pulses=%0d cnt=%0d want 0 0", pulses, fifo_count);
    end
    // ALU rd=0 leaves the port free for a queued load
    mem_rd = 9; mem_data = 32'h0000_0099;
    step();
    mem_valid = 0;
    step();
    vectors++;
    if (write_enable !== 1'b1 || write_reg !== 5'd9) begin
      miscompares++;
      $display("FAIL zero_rd_fifo: got we=%0b rd=%0d want 1 9", write_enable, write_reg);
    end
    idle(2);
  endtask

  task automatic test_starve();
    logic [ADDR_W-1:0] order[$];
    int pushed, lowrun, maxrun, nlow, first_low;
    bit acc;
    pushed = 0; lowrun = 0; maxrun = 0; nlow = 0; first_low = -1;
    alu_valid = 1;
    for (int c = 0; c < 70; c++) begin
      alu_rd = ADDR_W'(10 + (c % 8));
      alu_data = $urandom;
      mem_valid = (pushed < 5);
      mem_rd = ADDR_W'(pushed + 1);
      mem_data = 32'hA000_0000 + pushed + 1;
      acc = mem_valid && mem_ready;
      step();
      if (acc) begin
        pushed++;
        if (pushed == 4) begin
          vectors++;
          if (mem_ready !== 1'b0 || fifo_count !== CNT_W'(4)) begin
            miscompares++;
            $display("FAIL full: got mem_ready=%0b cnt=%0d want 0 4", mem_ready, fifo_count);
          end
        end
      end
      if (write_enable && write_reg < 10) order.push_back(write_reg);
      if (!alu_ready) begin
        if (first_low < 0) first_low = c;
        lowrun++;
        nlow++;
      end else begin
        lowrun = 0;
      end
      if (lowrun > maxrun) maxrun = lowrun;
    end
    vectors++;
    if (first_low != STARVE_LIMIT || maxrun != 1 || nlow != 5) begin
      miscompares++;
      $display("FAIL starve: got first_low=%0d maxrun=%0d drains=%0d want %0d 1 5",
               first_low, maxrun, nlow, STARVE_LIMIT);
    end
    vectors++;
    if (order.size() != 5) begin
      miscompares++;
      $display("FAIL drain_count: got %0d loads want 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (order[i] !== ADDR_W'(i + 1)) begin
          miscompares++;
          $display("FAIL drain_order: position %0d got rd=%0d want %0d", i, order[i], i + 1);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_reset_mid_drain();
    bit found;
    found = 0;
    alu_valid = 1; alu_rd = 20; alu_data = 32'hCAFE_0000;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1; mem_rd = ADDR_W'(i + 1); mem_data = 32'hB000_0000 + i;
      step();
    end
    mem_valid = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!alu_ready) found = 1;
      else step();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL drain_timeout: got alu_ready=%0b want 0 within 20 cycles", alu_ready);
    end
    reset = 1;
    step();
    reset = 0;
    vectors++;
    if (fifo_count !== '0 || write_enable !== 1'b0 || alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_drain: got cnt=%0d we=%0b ar=%0b want 0 0 1",
               fifo_count, write_enable, alu_ready);
    end
    idle(3);
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    alu_valid = 1; alu_rd = 12; alu_data = 32'h0000_1234;
    mem_valid = 1; mem_rd = 7; mem_data = 32'h11;
    step();
    mem_data = 32'h22;
    step();
    mem_valid = 0;
    byp_reg1 = 7; byp_reg2 = 0;
    #1;
    vectors++;
    if (byp_hit1 !== 1'b1 || byp_data1 !== 32'h22 || byp_hit2 !== 1'b0 || byp_data2 !== '0) begin
      miscompares++;
      $display("FAIL bypass_fifo: got h1=%0b d1=%h h2=%0b d2=%h want 1 22 0 0",
               byp_hit1, byp_data1, byp_hit2, byp_data2);
    end
    byp_reg1 = 6; byp_reg2 = 12;
    #1;
    vectors++;
    if (byp_hit1 !== 1'b0 || byp_data1 !== '0 || byp_hit2 !== 1'b1 || byp_data2 !== 32'h1234) begin
      miscompares++;
      $display("FAIL bypass_wb: got h1=%0b d1=%h h2=%0b d2=%h want 0 0 1 1234",
               byp_hit1, byp_data1, byp_hit2, byp_data2);
    end
    idle(4);
  endtask
`endif

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      alu_valid = ($urandom_range(0, 3) != 0);
      alu_rd    = ADDR_W'($urandom_range(0, 7));
      alu_data  = $urandom;
      mem_valid = ($urandom_range(0, 1) != 0);
      mem_rd    = ADDR_W'($urandom_range(0, 7));
      mem_data  = $urandom;
      step();
    end
    idle(40);
  endtask

  initial begin
    reset = 1; alu_valid = 0; alu_rd = '0; alu_data = '0;
    mem_valid = 0; mem_rd = '0; mem_data = '0;
`ifdef WB_BYPASS_EN
    byp_reg1 = '0; byp_reg2 = '0;
`endif
    #2;
    test_reset();
    test_alu_single();
    test_zero_rd();
    test_starve();
    test_reset_mid_drain();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
